// File: rtl/aes_inv_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_round_ctrl
//
// Purpose:
//   Sequencing controller for an iterative AES inverse cipher. It holds the
//   128-bit working state, asks an external key store for one round key per
//   cycle and hands the state to an external inverse-round datapath. One
//   block moves through IDLE -> ROUND (NR cycles) -> DONE -> IDLE.
//   The first AddRoundKey (with round key NR) happens on acceptance. After
//   that, each ROUND cycle loads the datapath result back into the state.
//   The last round (key 0) is the one that bypasses InvMixColumns.
//
// Parameters:
//   NR          number of cipher rounds (10, 12 or 14)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    ciphertext offered
//   in_ready    controller can accept a ciphertext (IDLE only)
//   ciphertext  128-bit input block
//   rk_idx      index of the round key wanted from the key store
//   rk          round key for rk_idx, returned in the same cycle
//   dp_state    current state register, fed to the inverse-round datapath
//   dp_mix      datapath applies InvMixColumns when 1
//   dp_next     datapath result for dp_state / rk / dp_mix
//   out_valid   plaintext valid (DONE)
//   out_ready   consumer accepts plaintext
//   plaintext   result block, zero unless out_valid
//   busy        high in ROUND and DONE
//   round       current round counter (debug), zero in IDLE and DONE
// ---------------------------------------------------------------------------
module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] dp_state,
  output logic         dp_mix,
  input  logic [127:0] dp_next,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Key index presented while idle (the initial AddRoundKey key) and the
  // round counter value loaded when a block is accepted.
  localparam logic [3:0] LAST_KEY    = 4'(NR);
  localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

  state_t       fsm_q;
  logic [127:0] state_q;
  logic [3:0]   round_q;
  logic [3:0]   rk_idx_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         dp_mix_q;

  // The FSM and all of its outputs live in this one register block. Each
  // output register is loaded with the value it must show in the state
  // being entered, so the outputs are glitch-free and line up with fsm_q.
  // rk_idx tracks the round counter while in ROUND. That way the key for
  // the round being computed is returned in the same cycle the datapath
  // needs it. In IDLE and DONE it rests at NR, ready for the next
  // acceptance. The unused fourth encoding falls back to a clean IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_q     <= '0;
      rk_idx_q    <= LAST_KEY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dp_mix_q    <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            fsm_q      <= ROUND;
            state_q    <= ciphertext ^ rk;
            round_q    <= FIRST_ROUND;
            rk_idx_q   <= FIRST_ROUND;
            dp_mix_q   <= (FIRST_ROUND != 4'd0);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        ROUND: begin
          state_q <= dp_next;
          if (round_q != 4'd0) begin
            round_q  <= round_q - 4'd1;
            rk_idx_q <= round_q - 4'd1;
            dp_mix_q <= (round_q != 4'd1);
          end else begin
            fsm_q       <= DONE;
            rk_idx_q    <= LAST_KEY;
            dp_mix_q    <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          fsm_q       <= IDLE;
          state_q     <= '0;
          round_q     <= '0;
          rk_idx_q    <= LAST_KEY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          dp_mix_q    <= 1'b0;
        end
      endcase
    end
  end

  // Plaintext is gated so downstream logic never sees intermediate states.
  assign plaintext = out_valid_q ? state_q : '0;
  assign dp_state  = state_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dp_mix    = dp_mix_q;
  assign rk_idx    = rk_idx_q;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_round_ctrl
//
// Purpose:
//   Directed bench for aes_inv_round_ctrl. Two instances are used: NR=10
//   (FIPS-197 C.1) and NR=14 (FIPS-197 C.3). The bench supplies the
//   external key store and the inverse-round datapath from its own AES
//   model. The S-box tables and key schedules are built at time zero.
//   The model works in FIPS byte order: byte 0 is in bits [127:120].
//   It is bit-reversed onto the ports, where bit 0 is the MSB of byte 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_inv_round_ctrl;

  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_REF = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_dp_mix, a_busy;
  logic [127:0] a_ciphertext, a_rk, a_dp_state, a_dp_next, a_plaintext;
  logic [3:0]   a_rk_idx, a_round;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dp_mix, b_busy;
  logic [127:0] b_ciphertext, b_rk, b_dp_state, b_dp_next, b_plaintext;
  logic [3:0]   b_rk_idx, b_round;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] ks10    [15];
  logic [127:0] ks14    [15];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  aes_inv_round_ctrl #(.NR(10)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .ciphertext(a_ciphertext),
    .rk_idx(a_rk_idx), .rk(a_rk), .dp_state(a_dp_state), .dp_mix(a_dp_mix),
    .dp_next(a_dp_next), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .plaintext(a_plaintext), .busy(a_busy), .round(a_round)
  );

  aes_inv_round_ctrl #(.NR(14)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .ciphertext(b_ciphertext),
    .rk_idx(b_rk_idx), .rk(b_rk), .dp_state(b_dp_state), .dp_mix(b_dp_mix),
    .dp_next(b_dp_next), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .plaintext(b_plaintext), .busy(b_busy), .round(b_round)
  );

  // Port layout <-> FIPS layout: a full bit reversal of the 128-bit word.
  function automatic logic [127:0] rev128(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 128; i++) o[i] = x[127-i];
    return o;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // One inverse round in FIPS order: InvShiftRows, InvSubBytes,
  // AddRoundKey, then optionally InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r+4*c] = isbox_t[a[r+4*((c-r+4)%4)]] ^ k[127-8*(r+4*c) -: 8];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a[4*c]   = gmul(b[4*c],8'h0e) ^ gmul(b[4*c+1],8'h0b) ^ gmul(b[4*c+2],8'h0d) ^ gmul(b[4*c+3],8'h09);
        a[4*c+1] = gmul(b[4*c],8'h09) ^ gmul(b[4*c+1],8'h0e) ^ gmul(b[4*c+2],8'h0b) ^ gmul(b[4*c+3],8'h0d);
        a[4*c+2] = gmul(b[4*c],8'h0d) ^ gmul(b[4*c+1],8'h09) ^ gmul(b[4*c+2],8'h0e) ^ gmul(b[4*c+3],8'h0b);
        a[4*c+3] = gmul(b[4*c],8'h0b) ^ gmul(b[4*c+1],8'h0d) ^ gmul(b[4*c+2],8'h09) ^ gmul(b[4*c+3],8'h0e);
      end
      for (int i = 0; i < 16; i++) b[i] = a[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  task automatic build_tables();
    logic [7:0] v, inv, s;
    for (int i = 0; i < 256; i++) begin
      v   = 8'(i);
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, v);
      if (v == 8'h00) inv = 8'h00;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[i]  = s;
      isbox_t[s] = v;
    end
  endtask

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr, input bit to14);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] rkv;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      rkv = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (to14) ks14[r] = rkv;
      else      ks10[r] = rkv;
    end
  endtask

  // External key stores and inverse-round datapaths for both instances.
  always_comb begin
    a_rk = '0;
    if (a_rk_idx <= 4'd10) a_rk = rev128(ks10[a_rk_idx]);
    a_dp_next = rev128(inv_round(rev128(a_dp_state), rev128(a_rk), a_dp_mix));
  end

  always_comb begin
    b_rk = '0;
    if (b_rk_idx <= 4'd14) b_rk = rev128(ks14[b_rk_idx]);
    b_dp_next = rev128(inv_round(rev128(b_dp_state), rev128(b_rk), b_dp_mix));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    a_ciphertext = rev128(CT_C1);
    tick();
    tick();
    checks++; if (a_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", a_in_ready); else passed++;
    checks++; if (a_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", a_busy); else passed++;
    checks++; if (a_out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", a_out_valid); else passed++;
    checks++; if (a_round !== 4'd0) $display("[TB] FAIL reset_round: got %0d expected 0", a_round); else passed++;
    checks++; if (a_plaintext !== 128'h0) $display("[TB] FAIL reset_plaintext: got %h expected 0", a_plaintext); else passed++;
    checks++; if (a_dp_state !== 128'h0) $display("[TB] FAIL reset_dp_state: got %h expected 0", a_dp_state); else passed++;
    checks++; if (a_rk_idx !== 4'd10) $display("[TB] FAIL reset_rk_idx: got %0d expected 10", a_rk_idx); else passed++;
    checks++; if (a_dp_mix !== 1'b0) $display("[TB] FAIL reset_dp_mix: got %b expected 0", a_dp_mix); else passed++;
    checks++; if (b_rk_idx !== 4'd14) $display("[TB] FAIL reset_rk_idx_nr14: got %0d expected 14", b_rk_idx); else passed++;
    checks++; if (b_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready_nr14: got %b expected 1", b_in_ready); else passed++;
    a_in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) $display("[TB] FAIL idle_out_ready_ignored: out_valid %b busy %b expected 0 0", a_out_valid, a_busy); else passed++;
  endtask

  // One C.1 block through the NR=10 instance with out_ready high. With
  // noise set, in_valid stays high with random ciphertext until after the
  // output handshake edge.
  task automatic run_c1_block(input string tag, input bit noise);
    logic [127:0] exp_pt;
    logic         exp_mix;
    exp_pt = rev128(PT_REF);
    a_ciphertext = rev128(CT_C1);
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    checks++; if (a_in_ready !== 1'b1) $display("[TB] FAIL %s_idle_ready: got %b expected 1", tag, a_in_ready); else passed++;
    checks++; if (a_rk_idx !== 4'd10) $display("[TB] FAIL %s_rk_idx_first: got %0d expected 10", tag, a_rk_idx); else passed++;
    tick();
    if (!noise) a_in_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      exp_mix = ((10 - n) != 0);
      checks++; if (a_rk_idx !== 4'(10 - n)) $display("[TB] FAIL %s_rk_idx cycle %0d: got %0d expected %0d", tag, n, a_rk_idx, 10 - n); else passed++;
      checks++; if (a_round !== 4'(10 - n)) $display("[TB] FAIL %s_round cycle %0d: got %0d expected %0d", tag, n, a_round, 10 - n); else passed++;
      checks++; if (a_dp_mix !== exp_mix) $display("[TB] FAIL %s_dp_mix cycle %0d: got %b expected %b", tag, n, a_dp_mix, exp_mix); else passed++;
      checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) $display("[TB] FAIL %s_round_flags cycle %0d: out_valid %b in_ready %b expected 0 0", tag, n, a_out_valid, a_in_ready); else passed++;
      if (noise) a_ciphertext = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    checks++; if (a_out_valid !== 1'b1) $display("[TB] FAIL %s_out_valid_latency: got %b expected 1", tag, a_out_valid); else passed++;
    checks++; if (a_plaintext !== exp_pt) $display("[TB] FAIL %s_plaintext: got %h expected %h", tag, a_plaintext, exp_pt); else passed++;
    checks++; if (a_busy !== 1'b1 || a_round !== 4'd0 || a_in_ready !== 1'b0) $display("[TB] FAIL %s_done_flags: busy %b round %0d in_ready %b expected 1 0 0", tag, a_busy, a_round, a_in_ready); else passed++;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_plaintext !== 128'h0) $display("[TB] FAIL %s_after_handshake: out_valid %b plaintext %h expected 0 0", tag, a_out_valid, a_plaintext); else passed++;
    checks++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0) $display("[TB] FAIL %s_no_overlap: in_ready %b busy %b expected 1 0", tag, a_in_ready, a_busy); else passed++;
    a_in_valid = 1'b0;
  endtask

  task automatic test_fips_c1();
    run_c1_block("c1", 1'b0);
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_pt;
    exp_pt = rev128(PT_REF);
    a_ciphertext = rev128(CT_C1);
    a_in_valid = 1'b1;
    a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (a_out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid cycle %0d: got %b expected 1", k, a_out_valid); else passed++;
      checks++; if (a_plaintext !== exp_pt) $display("[TB] FAIL bp_plaintext cycle %0d: got %h expected %h", k, a_plaintext, exp_pt); else passed++;
      checks++; if (a_in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready cycle %0d: got %b expected 0", k, a_in_ready); else passed++;
      a_in_valid = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    checks++; if (a_out_valid !== 1'b1 || a_plaintext !== exp_pt) $display("[TB] FAIL bp_held: out_valid %b plaintext %h expected 1 %h", a_out_valid, a_plaintext, exp_pt); else passed++;
    tick();
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("[TB] FAIL bp_release: in_ready %b out_valid %b expected 1 0", a_in_ready, a_out_valid); else passed++;
  endtask

  task automatic test_mid_reset();
    a_ciphertext = rev128(CT_C1);
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (a_round !== 4'd5) $display("[TB] FAIL midrst_round_before: got %0d expected 5", a_round); else passed++;
    rst_n = 1'b0;
    a_in_valid = 1'b1;
    tick();
    checks++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) $display("[TB] FAIL midrst_flags: busy %b out_valid %b expected 0 0", a_busy, a_out_valid); else passed++;
    checks++; if (a_plaintext !== 128'h0 || a_dp_state !== 128'h0) $display("[TB] FAIL midrst_state: plaintext %h dp_state %h expected 0 0", a_plaintext, a_dp_state); else passed++;
    checks++; if (a_in_ready !== 1'b1 || a_round !== 4'd0) $display("[TB] FAIL midrst_idle: in_ready %b round %0d expected 1 0", a_in_ready, a_round); else passed++;
    rst_n = 1'b1;
    a_in_valid = 1'b0;
    run_c1_block("post_reset", 1'b0);
  endtask

  task automatic test_input_while_busy();
    run_c1_block("busy_in", 1'b1);
  endtask

  task automatic test_back_to_back();
    int           acc_t [2];
    logic [127:0] res [2];
    int           n_acc, n_res;
    bit           drop;
    logic [127:0] exp_pt;
    exp_pt = rev128(PT_REF);
    n_acc = 0;
    n_res = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    res[0] = '0;
    res[1] = '0;
    a_ciphertext = rev128(CT_C1);
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drop = 1'b0;
      if (a_in_valid && a_in_ready && n_acc < 2) begin
        acc_t[n_acc] = c;
        n_acc++;
        if (n_acc == 2) drop = 1'b1;
      end
      if (a_out_valid && a_out_ready && n_res < 2) begin
        res[n_res] = a_plaintext;
        n_res++;
      end
      tick();
      if (drop) a_in_valid = 1'b0;
      if (n_res == 2) break;
    end
    a_in_valid = 1'b0;
    checks++; if (n_acc != 2) $display("[TB] FAIL b2b_accept_count: got %0d expected 2", n_acc); else passed++;
    checks++; if (acc_t[1] - acc_t[0] != 12) $display("[TB] FAIL b2b_spacing: got %0d expected 12", acc_t[1] - acc_t[0]); else passed++;
    checks++; if (n_res != 2) $display("[TB] FAIL b2b_result_count: got %0d expected 2", n_res); else passed++;
    checks++; if (res[0] !== exp_pt) $display("[TB] FAIL b2b_plaintext0: got %h expected %h", res[0], exp_pt); else passed++;
    checks++; if (res[1] !== exp_pt) $display("[TB] FAIL b2b_plaintext1: got %h expected %h", res[1], exp_pt); else passed++;
  endtask

  task automatic test_nr14();
    logic [127:0] exp_pt;
    exp_pt = rev128(PT_REF);
    b_ciphertext = rev128(CT_C3);
    b_in_valid = 1'b1;
    b_out_ready = 1'b1;
    checks++; if (b_rk_idx !== 4'd14 || b_in_ready !== 1'b1) $display("[TB] FAIL nr14_idle: rk_idx %0d in_ready %b expected 14 1", b_rk_idx, b_in_ready); else passed++;
    tick();
    b_in_valid = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      checks++; if (b_rk_idx !== 4'(14 - n)) $display("[TB] FAIL nr14_rk_idx cycle %0d: got %0d expected %0d", n, b_rk_idx, 14 - n); else passed++;
      checks++; if (b_out_valid !== 1'b0) $display("[TB] FAIL nr14_early_valid cycle %0d: got %b expected 0", n, b_out_valid); else passed++;
      tick();
    end
    checks++; if (b_out_valid !== 1'b1) $display("[TB] FAIL nr14_out_valid: got %b expected 1", b_out_valid); else passed++;
    checks++; if (b_plaintext !== exp_pt) $display("[TB] FAIL nr14_plaintext: got %h expected %h", b_plaintext, exp_pt); else passed++;
    tick();
    checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) $display("[TB] FAIL nr14_release: in_ready %b out_valid %b expected 1 0", b_in_ready, b_out_valid); else passed++;
  endtask

  // Safety net in case the design stalls a handshake the bench waits on.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    a_ciphertext = '0;
    b_in_valid = 1'b0;
    b_out_ready = 1'b0;
    b_ciphertext = '0;
    build_tables();
    expand_key({KEY128, 128'h0}, 4, 10, 1'b0);
    expand_key(KEY256, 8, 14, 1'b1);
    $display("[TB] key tables ready, starting directed tests");
    test_reset();
    test_fips_c1();
    test_backpressure();
    test_mid_reset();
    test_input_while_busy();
    test_back_to_back();
    test_nr14();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
